// File: rtl/controlador_botoes.sv
// -----------------------------------------------------------------------------
// controlador_botoes
//   Multi-channel push-button front end. Each raw pin is polarity-corrected,
//   passed through a two-flop synchroniser and a debounce counter, then
//   tracked by a small hold FSM that emits one-cycle press / release /
//   short-click / long-press / auto-repeat pulses.
//
// Ports
//   clk      : system clock, all logic on posedge
//   rst_n    : asynchronous active-low reset
//   b_in     : raw asynchronous button pins (one per channel)
//   b_nivel  : debounced level, 1 = pressed
//   b_press  : 1-cycle pulse when the debounced level rises
//   b_solta  : 1-cycle pulse when the debounced level falls
//   b_curto  : 1-cycle pulse on release if no long-press fired in that press
//   b_longo  : 1-cycle pulse once per press after LONGO_CICLOS of hold
//   b_repete : 1-cycle pulse every REPETE_CICLOS after b_longo while held
// -----------------------------------------------------------------------------
module controlador_botoes #(
  parameter int unsigned N_BOTOES        = 3,
  parameter bit          ATIVO_ALTO      = 1'b1,
  parameter logic [15:0] DEBOUNCE_CICLOS = 16'd50000,
  parameter logic [31:0] LONGO_CICLOS    = 32'd25000000,
  parameter logic [31:0] REPETE_CICLOS   = 32'd5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BOTOES-1:0] b_in,
  output logic [N_BOTOES-1:0] b_nivel,
  output logic [N_BOTOES-1:0] b_press,
  output logic [N_BOTOES-1:0] b_solta,
  output logic [N_BOTOES-1:0] b_curto,
  output logic [N_BOTOES-1:0] b_longo,
  output logic [N_BOTOES-1:0] b_repete
);

  localparam int unsigned DW    = $clog2(32'(DEBOUNCE_CICLOS) + 32'd1);
  localparam logic [31:0] H_MAX = (LONGO_CICLOS > REPETE_CICLOS) ? LONGO_CICLOS : REPETE_CICLOS;
  localparam int unsigned HW    = $clog2(64'(H_MAX) + 64'd1);

  // Terminal counts: the event fires on the edge after the counter sits here.
  localparam logic [DW-1:0] DEB_ULT    = DW'(DEBOUNCE_CICLOS - 16'd1);
  localparam logic [HW-1:0] LONGO_ULT  = HW'(LONGO_CICLOS - 32'd1);
  localparam bit            REPETE_ON  = (REPETE_CICLOS != 32'd0);
  localparam logic [HW-1:0] REPETE_ULT = REPETE_ON ? HW'(REPETE_CICLOS - 32'd1) : '0;

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    PRESSIONADO = 2'd1,
    LONGO       = 2'd2
  } estado_t;

  // Inversion happens before the synchroniser so everything downstream
  // sees 1 = pressed regardless of board wiring.
  logic [N_BOTOES-1:0] b_corr_s;
  assign b_corr_s = ATIVO_ALTO ? b_in : ~b_in;

  for (genvar g = 0; g < N_BOTOES; g++) begin : g_canal
    logic [1:0]    sinc_q;
    logic [DW-1:0] deb_q;
    logic [HW-1:0] h_q;
    estado_t       estado_q;
    logic          nivel_q;
    logic          press_q, solta_q, curto_q, longo_q, repete_q;
    logic          s_s;
    logic          vira_s;

    assign s_s = sinc_q[1];
    // Debounced level flips on this edge; shared by the debouncer and the
    // FSM so press/release pulses line up with the new level.
    assign vira_s = (s_s != nivel_q) && (deb_q == DEB_ULT);

    // Two-flop synchroniser, reset to the released (corrected) value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sinc_q <= 2'b00;
      end else begin
        sinc_q <= {sinc_q[0], b_corr_s[g]};
      end
    end

    // Debounce: any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_q   <= '0;
        nivel_q <= 1'b0;
      end else if (s_s == nivel_q) begin
        deb_q <= '0;
      end else if (vira_s) begin
        deb_q   <= '0;
        nivel_q <= ~nivel_q;
      end else begin
        deb_q <= deb_q + DW'(1'b1);
      end
    end

    // Hold FSM with registered one-cycle event outputs. Release is checked
    // first so it always beats a long/repeat pulse due on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        estado_q <= SOLTO;
        h_q      <= '0;
        press_q  <= 1'b0;
        solta_q  <= 1'b0;
        curto_q  <= 1'b0;
        longo_q  <= 1'b0;
        repete_q <= 1'b0;
      end else begin
        press_q  <= 1'b0;
        solta_q  <= 1'b0;
        curto_q  <= 1'b0;
        longo_q  <= 1'b0;
        repete_q <= 1'b0;
        case (estado_q)
          SOLTO: begin
            h_q <= '0;
            if (vira_s) begin
              estado_q <= PRESSIONADO;
              press_q  <= 1'b1;
            end else begin
              estado_q <= SOLTO;
            end
          end
          PRESSIONADO: begin
            if (vira_s) begin
              estado_q <= SOLTO;
              h_q      <= '0;
              solta_q  <= 1'b1;
              curto_q  <= 1'b1;
            end else if (h_q == LONGO_ULT) begin
              estado_q <= LONGO;
              h_q      <= '0;
              longo_q  <= 1'b1;
            end else begin
              h_q <= h_q + HW'(1'b1);
            end
          end
          LONGO: begin
            if (vira_s) begin
              estado_q <= SOLTO;
              h_q      <= '0;
              solta_q  <= 1'b1;
            end else if (!REPETE_ON) begin
              h_q <= '0;
            end else if (h_q == REPETE_ULT) begin
              h_q      <= '0;
              repete_q <= 1'b1;
            end else begin
              h_q <= h_q + HW'(1'b1);
            end
          end
          default: begin
            estado_q <= SOLTO;
            h_q      <= '0;
          end
        endcase
      end
    end

    assign b_nivel[g]  = nivel_q;
    assign b_press[g]  = press_q;
    assign b_solta[g]  = solta_q;
    assign b_curto[g]  = curto_q;
    assign b_longo[g]  = longo_q;
    assign b_repete[g] = repete_q;
  end

endmodule

// File: tb/tb_controlador_botoes.sv
// -----------------------------------------------------------------------------
// tb_controlador_botoes
//   Directed bench for controlador_botoes. Three 2-channel instances with
//   DEBOUNCE=4, LONGO=10: u_a (REPETE=3, active-high), u_b (REPETE=0),
//   u_c (REPETE=3, active-low). Cycle c is the interval after clock edge c;
//   inputs are driven and outputs sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_controlador_botoes;

  localparam int NUNCA  = 100000;
  localparam int NENHUM = -1;

  logic clk;
  logic rst_n;
  logic [1:0] bin_a, bin_b, bin_c;
  logic [1:0] a_nivel, a_press, a_solta, a_curto, a_longo, a_repete;
  logic [1:0] b_nivel, b_press, b_solta, b_curto, b_longo, b_repete;
  logic [1:0] c_nivel, c_press, c_solta, c_curto, c_longo, c_repete;

  int testes = 0;
  int falhas = 0;

  controlador_botoes #(
    .N_BOTOES(2), .ATIVO_ALTO(1'b1), .DEBOUNCE_CICLOS(16'd4),
    .LONGO_CICLOS(32'd10), .REPETE_CICLOS(32'd3)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .b_in(bin_a),
    .b_nivel(a_nivel), .b_press(a_press), .b_solta(a_solta),
    .b_curto(a_curto), .b_longo(a_longo), .b_repete(a_repete)
  );

  controlador_botoes #(
    .N_BOTOES(2), .ATIVO_ALTO(1'b1), .DEBOUNCE_CICLOS(16'd4),
    .LONGO_CICLOS(32'd10), .REPETE_CICLOS(32'd0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .b_in(bin_b),
    .b_nivel(b_nivel), .b_press(b_press), .b_solta(b_solta),
    .b_curto(b_curto), .b_longo(b_longo), .b_repete(b_repete)
  );

  controlador_botoes #(
    .N_BOTOES(2), .ATIVO_ALTO(1'b0), .DEBOUNCE_CICLOS(16'd4),
    .LONGO_CICLOS(32'd10), .REPETE_CICLOS(32'd3)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .b_in(bin_c),
    .b_nivel(c_nivel), .b_press(c_press), .b_solta(c_solta),
    .b_curto(c_curto), .b_longo(c_longo), .b_repete(c_repete)
  );

  logic [11:0] obs_a, obs_b, obs_c;
  assign obs_a = {a_nivel, a_press, a_solta, a_curto, a_longo, a_repete};
  assign obs_b = {b_nivel, b_press, b_solta, b_curto, b_longo, b_repete};
  assign obs_c = {c_nivel, c_press, c_solta, c_curto, c_longo, c_repete};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {nivel,press,solta,curto,longo,repete} of one channel at cycle
  // cyc, given the cycle p where the level rises (NENHUM = never pressed),
  // the cycle r where it falls, and the repeat period (LONGO fixed at 10).
  function automatic logic [5:0] modelo(int cyc, int p, int r, int rep);
    logic [5:0] v;
    int lc;
    v = 6'b000000;
    if (p >= 0) begin
      lc   = p + 10;
      v[5] = (cyc >= p) && (cyc < r);
      v[4] = (cyc == p);
      v[3] = (cyc == r);
      v[2] = (cyc == r) && (r <= lc);
      v[1] = (cyc == lc) && (lc < r);
      v[0] = (rep != 0) && (cyc > lc) && (cyc < r) && (((cyc - lc) % rep) == 0);
    end
    return v;
  endfunction

  // Interleave two channel vectors into the packed observation layout.
  function automatic logic [11:0] junta(logic [5:0] c1, logic [5:0] c0);
    logic [11:0] e;
    e = 12'h000;
    for (int k = 0; k < 6; k++) begin
      e[2*k]   = c0[k];
      e[2*k+1] = c1[k];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [11:0] obs, input logic [11:0] esp);
    testes++;
    assert (obs === esp) else begin
      falhas++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    bin_a = 2'b00;
    bin_b = 2'b00;
    bin_c = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_a", 0, obs_a, 12'h000);
    chk("reset_b", 0, obs_b, 12'h000);
    chk("reset_c", 0, obs_c, 12'h000);
    tick();
    tick();
    rst_n = 1'b1;

    // Idle after reset: everything quiet.
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_a", c, obs_a, 12'h000);
      chk("idle_c", c, obs_c, 12'h000);
    end

    // Short click on channel 0.
    for (int c = 0; c <= 20; c++) begin
      chk("curto_a", c, obs_a, junta(modelo(c, NENHUM, NUNCA, 3), modelo(c, 6, 14, 3)));
      bin_a = (c < 8) ? 2'b01 : 2'b00;
      tick();
    end
    for (int c = 0; c < 10; c++) tick();

    // Glitch train: 3 high, 1 low, 3 high, low -> rejected.
    for (int c = 0; c <= 16; c++) begin
      chk("glitch_a", c, obs_a, 12'h000);
      bin_a = ((c < 3) || ((c >= 4) && (c < 7))) ? 2'b01 : 2'b00;
      tick();
    end
    for (int c = 0; c < 10; c++) tick();

    // Long press with auto-repeat on channel 1.
    for (int c = 0; c <= 45; c++) begin
      chk("longo_a", c, obs_a, junta(modelo(c, 6, 36, 3), modelo(c, NENHUM, NUNCA, 3)));
      bin_a = (c < 30) ? 2'b10 : 2'b00;
      tick();
    end
    for (int c = 0; c < 10; c++) tick();

    // Repeat disabled, both channels pressed together.
    for (int c = 0; c <= 45; c++) begin
      chk("semrep_b", c, obs_b, junta(modelo(c, 6, 36, 0), modelo(c, 6, 36, 0)));
      bin_b = (c < 30) ? 2'b11 : 2'b00;
      tick();
    end
    for (int c = 0; c < 10; c++) tick();

    // Active-low pins: channel 0 driven low for 8 cycles.
    for (int c = 0; c <= 20; c++) begin
      chk("baixo_c", c, obs_c, junta(modelo(c, NENHUM, NUNCA, 3), modelo(c, 6, 14, 3)));
      bin_c = (c < 8) ? 2'b10 : 2'b11;
      tick();
    end
    for (int c = 0; c < 10; c++) tick();

    // Reset while held: asynchronous clear, no release events afterwards.
    for (int c = 0; c < 10; c++) begin
      chk("segura_c", c, obs_c, junta(modelo(c, NENHUM, NUNCA, 3), modelo(c, 6, NUNCA, 3)));
      bin_c = 2'b10;
      tick();
    end
    chk("segura_c", 10, obs_c, junta(6'b000000, modelo(10, 6, NUNCA, 3)));
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_c", 10, obs_c, 12'h000);
    chk("rst_async_a", 10, obs_a, 12'h000);
    bin_c = 2'b11;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("pos_rst_c", c, obs_c, 12'h000);
    end

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
